// File: rtl/phase_search_pkg.sv
// Shared types and sizing helpers for the symbol-timing phase search controller.
package phase_search_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int unsigned NUM_PHASES = 4;
  localparam int unsigned PHASE_W    = $clog2(NUM_PHASES);

  // Counter must reach both SETTLE-1 and 2^win_log2-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned settle,
                                            input int unsigned win_log2);
    int unsigned win;
    int unsigned span;
    win  = 32'd1 << win_log2;
    span = (settle > win) ? settle : win;
    return (span < 32'd2) ? 32'd1 : 32'($clog2(span));
  endfunction

endpackage

// File: rtl/phase_search_ctrl_if.sv
// Control/status bundle between the phase search controller and its host/accumulator.
interface phase_search_ctrl_if
  import phase_search_pkg::*;
#(
  parameter int unsigned ACC_W = 56
);
  logic               sym_clk_en;
  logic               start;
  logic               abort;
  logic [ACC_W-1:0]   acc_val;
  logic               clr_acc;
  logic [PHASE_W-1:0] phase_sel;
  logic               busy;
  logic               done;
  logic [PHASE_W-1:0] best_phase;
  logic [ACC_W-1:0]   best_metric;

  modport master (
    output sym_clk_en, start, abort, acc_val,
    input  clr_acc, phase_sel, busy, done, best_phase, best_metric
  );

  modport slave (
    input  sym_clk_en, start, abort, acc_val,
    output clr_acc, phase_sel, busy, done, best_phase, best_metric
  );
endinterface

// File: rtl/phase_search_ctrl_sym_tick_cnt.sv
// Symbol-tick counter with a terminal-count strobe, shared by the SETTLE and MEASURE windows.
module sym_tick_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sym_clk_en,
  input  logic             clear,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (sym_clk_en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Strobes on the symbol tick that completes the window.
  assign tc = sym_clk_en && (cnt_q == limit);
endmodule

// File: rtl/phase_search_ctrl.sv
// Sweeps the four matched-filter taps, keeps the lowest-error one, and commits it to phase_sel.
// Define PHASE_SEARCH_CONT_EN to restart the sweep after every commit (continuous tracking).
module phase_search_ctrl
  import phase_search_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = 10,
  parameter int unsigned SETTLE   = 8,
  parameter int unsigned ACC_W    = 56
) (
  input logic                sys_clk,
  input logic                reset_n,
  phase_search_ctrl_if.slave bus
);
  localparam int unsigned        CNT_W       = cnt_width(SETTLE, WIN_LOG2);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE - 32'd1);
  localparam logic [CNT_W-1:0]   WIN_LAST    = CNT_W'((32'd1 << WIN_LOG2) - 32'd1);
  localparam logic [PHASE_W-1:0] LAST_PHASE  = PHASE_W'(NUM_PHASES - 32'd1);

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_sel_q, phase_sel_d;
  logic [PHASE_W-1:0] cand_phase_q, cand_phase_d;
  logic [ACC_W-1:0]   cand_metric_q, cand_metric_d;
  logic [PHASE_W-1:0] best_phase_q, best_phase_d;
  logic [ACC_W-1:0]   best_metric_q, best_metric_d;
  logic               busy_q, done_q;

  logic               clr_acc_c;
  logic               cnt_clear_c;
  logic [CNT_W-1:0]   cnt_limit_c;
  logic               tc;
  logic               take_c;
  logic [PHASE_W-1:0] fin_phase_c;
  logic [ACC_W-1:0]   fin_metric_c;

  sym_tick_cnt #(.CNT_W(CNT_W)) u_tick_cnt (
    .clk        (sys_clk),
    .rst_n      (reset_n),
    .sym_clk_en (bus.sym_clk_en),
    .clear      (cnt_clear_c),
    .limit      (cnt_limit_c),
    .tc         (tc)
  );

  // Strict compare: ties and an all-ones metric keep the earlier (lower) phase.
  assign take_c       = bus.acc_val < cand_metric_q;
  assign fin_phase_c  = take_c ? phase_sel_q : cand_phase_q;
  assign fin_metric_c = take_c ? bus.acc_val : cand_metric_q;

  always_comb begin
    state_d       = state_q;
    phase_sel_d   = phase_sel_q;
    cand_phase_d  = cand_phase_q;
    cand_metric_d = cand_metric_q;
    best_phase_d  = best_phase_q;
    best_metric_d = best_metric_q;
    clr_acc_c     = 1'b0;
    cnt_limit_c   = SETTLE_LAST;

    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      phase_sel_d = best_phase_q;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_d       = ST_SETTLE;
            phase_sel_d   = '0;
            cand_phase_d  = '0;
            cand_metric_d = '1;
          end
        end
        ST_SETTLE: begin
          cnt_limit_c = SETTLE_LAST;
          if (tc) begin
            clr_acc_c = 1'b1;
            state_d   = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          cnt_limit_c = WIN_LAST;
          if (tc) begin
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          cand_phase_d  = fin_phase_c;
          cand_metric_d = fin_metric_c;
          if (phase_sel_q == LAST_PHASE) begin
            // Commit lands together with done in the DONE cycle.
            state_d       = ST_DONE;
            best_phase_d  = fin_phase_c;
            best_metric_d = fin_metric_c;
            phase_sel_d   = fin_phase_c;
          end else begin
            state_d     = ST_SETTLE;
            phase_sel_d = phase_sel_q + PHASE_W'(1);
          end
        end
        ST_DONE: begin
`ifdef PHASE_SEARCH_CONT_EN
          state_d       = ST_SETTLE;
          phase_sel_d   = '0;
          cand_phase_d  = '0;
          cand_metric_d = '1;
`else
          state_d       = ST_IDLE;
          phase_sel_d   = cand_phase_q;
`endif
        end
        default: begin
          state_d     = ST_IDLE;
          phase_sel_d = best_phase_q;
        end
      endcase
    end

    // Restart the window on every state change and hold it at zero outside the windows.
    cnt_clear_c = (state_d != state_q) ||
                  !((state_q == ST_SETTLE) || (state_q == ST_MEASURE));
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      phase_sel_q   <= '0;
      cand_phase_q  <= '0;
      cand_metric_q <= '1;
      best_phase_q  <= '0;
      best_metric_q <= '1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_sel_q   <= phase_sel_d;
      cand_phase_q  <= cand_phase_d;
      cand_metric_q <= cand_metric_d;
      best_phase_q  <= best_phase_d;
      best_metric_q <= best_metric_d;
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
    end
  end

  assign bus.clr_acc     = clr_acc_c;
  assign bus.phase_sel   = phase_sel_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.best_phase  = best_phase_q;
  assign bus.best_metric = best_metric_q;
endmodule

// File: tb/tb_phase_search_ctrl.sv
// Directed bench for phase_search_ctrl: table-driven sweeps plus abort/reset/start-hold sequences.
module tb_phase_search_ctrl;
  localparam int unsigned ACC_W = 56;
  localparam logic [ACC_W-1:0] ONES = '1;

  typedef struct packed {
    logic [ACC_W-1:0] m0;
    logic [ACC_W-1:0] m1;
    logic [ACC_W-1:0] m2;
    logic [ACC_W-1:0] m3;
    logic [1:0]       exp_phase;
    logic [ACC_W-1:0] exp_metric;
  } vec_t;

  logic clk;
  logic rst_n;
  logic [ACC_W-1:0] metrics [4];
  int checks;
  int failures;
  int clr_cnt;
  int done_cnt;
  int tick_cnt;
  bit watch_busy;
  bit busy_drop;
  int div;

  phase_search_ctrl_if #(.ACC_W(ACC_W)) bus ();

  phase_search_ctrl #(.WIN_LOG2(4), .SETTLE(2), .ACC_W(ACC_W)) dut (
    .sys_clk (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accumulator model: returns the programmed error sum for the selected tap.
  always_comb bus.acc_val = metrics[bus.phase_sel];

  initial begin
    div = 0;
    bus.sym_clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div + 1) % 16;
      bus.sym_clk_en = (div == 15);
    end
  end

  always @(negedge clk) begin
    if (bus.clr_acc) clr_cnt++;
    if (bus.done) done_cnt++;
    if (bus.busy && bus.sym_clk_en) tick_cnt++;
    if (watch_busy && !bus.busy) busy_drop = 1'b1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [ACC_W-1:0] a, b, c, d,
                              input logic [1:0] ph, input logic [ACC_W-1:0] met);
    vec_t v;
    v.m0 = a; v.m1 = b; v.m2 = c; v.m3 = d;
    v.exp_phase = ph; v.exp_metric = met;
    return v;
  endfunction

  task automatic set_metrics(input vec_t v);
    metrics[0] = v.m0; metrics[1] = v.m1; metrics[2] = v.m2; metrics[3] = v.m3;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_phase_sel"}, 64'(bus.phase_sel), 64'd0);
    check({tag, "_best_phase"}, 64'(bus.best_phase), 64'd0);
    check({tag, "_best_metric"}, 64'(bus.best_metric), 64'(ONES));
    check({tag, "_clr_acc"}, 64'(bus.clr_acc), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    vec_t vecs [5];
    vec_t v;
    bit seen;
    int c0, t0, d0;

    checks = 0; failures = 0;
    clr_cnt = 0; done_cnt = 0; tick_cnt = 0;
    watch_busy = 1'b0; busy_drop = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0;
    for (int i = 0; i < 4; i++) metrics[i] = '0;

    vecs[0] = mk(56'd900, 56'd400, 56'd700, 56'd500, 2'd1, 56'd400);
    vecs[1] = mk(56'd300, 56'd300, 56'd300, 56'd300, 2'd0, 56'd300);
    vecs[2] = mk(ONES, ONES, ONES, ONES, 2'd0, ONES);
    vecs[3] = mk(56'd500, 56'd500, 56'd200, 56'd200, 2'd2, 56'd200);
    vecs[4] = mk(56'd800, 56'd700, 56'd600, 56'd100, 2'd3, 56'd100);

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef PHASE_SEARCH_CONT_EN
    set_metrics(mk(56'd9, 56'd9, 56'd1, 56'd9, 2'd2, 56'd1));
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    watch_busy = 1'b1;
    wait_done(2000, seen);
    check("cont_done1_seen", 64'(seen), 64'd1);
    check("cont_done1_phase_sel", 64'(bus.phase_sel), 64'd2);
    set_metrics(mk(56'd1, 56'd9, 56'd9, 56'd9, 2'd0, 56'd1));
    wait_done(2000, seen);
    check("cont_done2_seen", 64'(seen), 64'd1);
    check("cont_done2_phase_sel", 64'(bus.phase_sel), 64'd0);
    check("cont_done2_metric", 64'(bus.best_metric), 64'd1);
    check("cont_done_count", 64'(done_cnt - d0), 64'd2);
    check("cont_busy_never_dropped", 64'(busy_drop), 64'd0);
    watch_busy = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    check("cont_abort_busy", 64'(bus.busy), 64'd0);
`else
    // Full sweeps from the vector table.
    for (int k = 0; k < 5; k++) begin
      v = vecs[k];
      set_metrics(v);
      c0 = clr_cnt; t0 = tick_cnt;
      pulse_start();
      wait_done(2000, seen);
      check($sformatf("v%0d_done_seen", k), 64'(seen), 64'd1);
      check($sformatf("v%0d_best_phase", k), 64'(bus.best_phase), 64'(v.exp_phase));
      check($sformatf("v%0d_best_metric", k), 64'(bus.best_metric), 64'(v.exp_metric));
      check($sformatf("v%0d_phase_sel_at_done", k), 64'(bus.phase_sel), 64'(v.exp_phase));
      check($sformatf("v%0d_clr_pulses", k), 64'(clr_cnt - c0), 64'd4);
      check($sformatf("v%0d_sym_ticks", k), 64'(tick_cnt - t0), 64'd72);
      @(negedge clk);
      check($sformatf("v%0d_busy_after_done", k), 64'(bus.busy), 64'd0);
      check($sformatf("v%0d_idle_phase_sel", k), 64'(bus.phase_sel), 64'(v.exp_phase));
    end

    // Abort during phase 2 SETTLE; phase 3 / 100 is committed from the last vector.
    set_metrics(mk(56'd10, 56'd10, 56'd10, 56'd10, 2'd0, 56'd10));
    d0 = done_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.phase_sel == 2'd2) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_reached_phase2", 64'(seen), 64'd1);
    repeat (3) @(negedge clk);
    c0 = clr_cnt;
    bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_phase_sel", 64'(bus.phase_sel), 64'd3);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_best_metric", 64'(bus.best_metric), 64'd100);
    check("abort_best_phase", 64'(bus.best_phase), 64'd3);
    repeat (300) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_no_clr", 64'(clr_cnt - c0), 64'd0);

    // start and abort together in IDLE: abort wins.
    @(posedge clk); #1 begin bus.start = 1'b1; bus.abort = 1'b1; end
    @(posedge clk); #1 begin bus.start = 1'b0; bus.abort = 1'b0; end
    @(negedge clk);
    check("start_abort_idle_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("start_abort_idle_busy2", 64'(bus.busy), 64'd0);

    // start held for 50 cycles: exactly one sweep.
    set_metrics(vecs[0]);
    d0 = done_cnt;
    @(posedge clk); #1 bus.start = 1'b1;
    repeat (50) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(2000, seen);
    check("hold_done_seen", 64'(seen), 64'd1);
    repeat (300) @(negedge clk);
    check("hold_done_count", 64'(done_cnt - d0), 64'd1);
    check("hold_busy", 64'(bus.busy), 64'd0);
    check("hold_best_phase", 64'(bus.best_phase), 64'd1);

    // Asynchronous reset in the middle of MEASURE.
    c0 = clr_cnt;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (clr_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_reached_measure", 64'(seen), 64'd1);
    repeat (20) @(negedge clk);
    check("rst_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_release_busy", 64'(bus.busy), 64'd0);
    check("rst_release_phase_sel", 64'(bus.phase_sel), 64'd0);
    repeat (5) @(negedge clk);
    check("rst_stays_idle", 64'(bus.busy), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
